// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command-bus sequencer/arbiter: holds the bus for init, then grants it to
// auto-refresh, self-refresh, write or read. Self-refresh is built in only with SDRAM_ARB_SREF_EN.
//
// state   | meaning
// --------+---------------------------------------------------
// S_INIT  | power-up init owns the bus, waiting for init_done
// S_ARB   | idle/arbitrating, NOP driven on the bus
// S_AREF  | auto-refresh module granted
// S_SREF  | self-refresh module granted (owns cke)
// S_WRITE | write module granted
// S_READ  | read module granted
module sdram_cmd_arbiter #(
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_done,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_done,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [11:0] aref_addr,
  input  logic        sref_req,
  input  logic        sref_done,
  input  logic [3:0]  sref_cmd,
  input  logic [1:0]  sref_ba,
  input  logic [11:0] sref_addr,
  input  logic        sref_cke,
  input  logic        wr_req,
  input  logic        wr_done,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  input  logic        rd_req,
  input  logic        rd_done,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,
  output logic        aref_en,
  output logic        sref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARB   = 3'd1,
    S_AREF  = 3'd2,
    S_SREF  = 3'd3,
    S_WRITE = 3'd4,
    S_READ  = 3'd5
  } state_t;

  state_t state, state_nxt;
  logic   last_rw;  // 1: write was served last, 0: read

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_INIT;
      last_rw <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_ARB && state_nxt == S_WRITE)
        last_rw <= 1'b1;
      else if (state == S_ARB && state_nxt == S_READ)
        last_rw <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: if (init_done) state_nxt = S_ARB;
      S_ARB: begin
        if (aref_req)
          state_nxt = S_AREF;
`ifdef SDRAM_ARB_SREF_EN
        else if (sref_req)
          state_nxt = S_SREF;
`endif
        else if (wr_req && rd_req)
          state_nxt = last_rw ? S_READ : S_WRITE;
        else if (wr_req)
          state_nxt = S_WRITE;
        else if (rd_req)
          state_nxt = S_READ;
      end
      S_AREF:  if (aref_done) state_nxt = S_ARB;
`ifdef SDRAM_ARB_SREF_EN
      S_SREF:  if (sref_done) state_nxt = S_ARB;
`endif
      S_WRITE: if (wr_done)   state_nxt = S_ARB;
      S_READ:  if (rd_done)   state_nxt = S_ARB;
      default: state_nxt = S_INIT;
    endcase
  end

  assign aref_en = (state == S_AREF);
  assign wr_en   = (state == S_WRITE);
  assign rd_en   = (state == S_READ);

`ifdef SDRAM_ARB_SREF_EN
  assign sref_en   = (state == S_SREF);
  assign sdram_cke = (state == S_SREF) ? sref_cke : 1'b1;
`else
  // Self-refresh pins kept for pin compatibility only.
  logic unused_sref;
  assign unused_sref = ^{sref_req, sref_done, sref_cmd, sref_ba, sref_addr, sref_cke};
  assign sref_en     = 1'b0;
  assign sdram_cke   = 1'b1;
`endif

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_ba   = 2'b00;
    sdram_addr = 12'h000;
    case (state)
      S_INIT:  begin sdram_cmd = init_cmd; sdram_ba = init_ba; sdram_addr = init_addr; end
      S_AREF:  begin sdram_cmd = aref_cmd; sdram_ba = aref_ba; sdram_addr = aref_addr; end
`ifdef SDRAM_ARB_SREF_EN
      S_SREF:  begin sdram_cmd = sref_cmd; sdram_ba = sref_ba; sdram_addr = sref_addr; end
`endif
      S_WRITE: begin sdram_cmd = wr_cmd;   sdram_ba = wr_ba;   sdram_addr = wr_addr;   end
      S_READ:  begin sdram_cmd = rd_cmd;   sdram_ba = rd_ba;   sdram_addr = rd_addr;   end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Scoreboard bench for sdram_cmd_arbiter: expected grant order is queued when requests
// are raised and popped as grants appear. Self-refresh scenarios follow SDRAM_ARB_SREF_EN.
module tb_sdram_cmd_arbiter;

  localparam int G_NONE = 0, G_AREF = 1, G_SREF = 2, G_WR = 3, G_RD = 4, G_MULTI = 9;
  localparam logic [17:0] BUS_NOP = {4'b0111, 2'b00, 12'h000};

  logic        sys_clk, sys_rst_n, init_done;
  logic [3:0]  init_cmd, aref_cmd, sref_cmd, wr_cmd, rd_cmd, sdram_cmd;
  logic [1:0]  init_ba, aref_ba, sref_ba, wr_ba, rd_ba, sdram_ba;
  logic [11:0] init_addr, aref_addr, sref_addr, wr_addr, rd_addr, sdram_addr;
  logic        aref_req, aref_done, sref_req, sref_done, sref_cke;
  logic        wr_req, wr_done, rd_req, rd_done;
  logic        aref_en, sref_en, wr_en, rd_en, sdram_cke;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  sdram_cmd_arbiter #(.CMD_NOP(4'b0111)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_done(aref_done),
    .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
    .sref_req(sref_req), .sref_done(sref_done),
    .sref_cmd(sref_cmd), .sref_ba(sref_ba), .sref_addr(sref_addr), .sref_cke(sref_cke),
    .wr_req(wr_req), .wr_done(wr_done),
    .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .rd_req(rd_req), .rd_done(rd_done),
    .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .sref_en(sref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] bus_exp(input int id);
    case (id)
      G_AREF:  return {aref_cmd, aref_ba, aref_addr};
      G_SREF:  return {sref_cmd, sref_ba, sref_addr};
      G_WR:    return {wr_cmd, wr_ba, wr_addr};
      G_RD:    return {rd_cmd, rd_ba, rd_addr};
      default: return BUS_NOP;
    endcase
  endfunction

  function automatic int cur_grant();
    int n;
    n = int'(aref_en) + int'(sref_en) + int'(wr_en) + int'(rd_en);
    if (n > 1)   return G_MULTI;
    if (aref_en) return G_AREF;
    if (sref_en) return G_SREF;
    if (wr_en)   return G_WR;
    if (rd_en)   return G_RD;
    return G_NONE;
  endfunction

  function automatic logic [17:0] bus_now();
    return {sdram_cmd, sdram_ba, sdram_addr};
  endfunction

  function automatic int pop_exp();
    if (exp_q.size() == 0) return -1;
    return exp_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_done(input int id, input logic v);
    case (id)
      G_AREF: aref_done = v;
      G_SREF: sref_done = v;
      G_WR:   wr_done   = v;
      G_RD:   rd_done   = v;
      default: ;
    endcase
  endtask

  task automatic wait_grant(output int id, output int cycles);
    id = G_NONE;
    cycles = 0;
    for (int i = 0; i < 20 && id == G_NONE; i++) begin
      tick();
      cycles++;
      id = cur_grant();
    end
  endtask

  // mode 0: requests stay up, 1: granted module drops its request with done, 2: all drop
  task automatic grant_cycle(input int hold, input int mode, output int got, output int lat,
                             output bit bus_ok, output bit held_ok, output bit nop_ok);
    wait_grant(got, lat);
    bus_ok  = (got != G_NONE) && (bus_now() === bus_exp(got));
    held_ok = 1'b1;
    if (got == G_WR) rd_done = 1'b1; else wr_done = 1'b1;
    tick();
    rd_done = 1'b0;
    wr_done = 1'b0;
    held_ok = held_ok && (cur_grant() == got);
    for (int i = 2; i < hold; i++) begin
      tick();
      held_ok = held_ok && (cur_grant() == got);
    end
    set_done(got, 1'b1);
    if (mode == 1) begin
      case (got)
        G_AREF: aref_req = 1'b0;
        G_SREF: sref_req = 1'b0;
        G_WR:   wr_req   = 1'b0;
        G_RD:   rd_req   = 1'b0;
        default: ;
      endcase
    end else if (mode == 2) begin
      aref_req = 1'b0; sref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    end
    tick();
    set_done(got, 1'b0);
    nop_ok = (cur_grant() == G_NONE) && (bus_now() === BUS_NOP);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if (cur_grant() !== G_NONE || sdram_cke !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs: grant=%0d cke=%b, required grant=0 cke=1", cur_grant(), sdram_cke);
    end
    vectors++;
    if (bus_now() !== {init_cmd, init_ba, init_addr}) begin
      miscompares++;
      $display("FAIL reset_bus: got %h, required %h", bus_now(), {init_cmd, init_ba, init_addr});
    end
    init_cmd = 4'b0010; init_addr = 12'h1a5;
    #1;
    vectors++;
    if (bus_now() !== {4'b0010, init_ba, 12'h1a5}) begin
      miscompares++;
      $display("FAIL reset_bus_follow: got %h, required %h", bus_now(), {4'b0010, init_ba, 12'h1a5});
    end
    sys_rst_n = 1'b1;
    wr_req = 1'b1;  // ignored while INIT
    for (int c = 1; c <= 5; c++) begin
      tick();
      vectors++;
      if (cur_grant() !== G_NONE || bus_now() !== {init_cmd, init_ba, init_addr}) begin
        miscompares++;
        $display("FAIL init_hold c%0d: grant=%0d bus=%h, required grant=0 bus=%h",
                 c, cur_grant(), bus_now(), {init_cmd, init_ba, init_addr});
      end
    end
    wr_req = 1'b0;
    init_done = 1'b1;
    tick();
    vectors++;
    if (cur_grant() !== G_NONE || bus_now() !== BUS_NOP || sdram_cke !== 1'b1) begin
      miscompares++;
      $display("FAIL init_to_arb: grant=%0d bus=%h cke=%b, required grant=0 bus=%h cke=1",
               cur_grant(), bus_now(), sdram_cke, BUS_NOP);
    end
    repeat (3) tick();
    vectors++;
    if (cur_grant() !== G_NONE || bus_now() !== BUS_NOP) begin
      miscompares++;
      $display("FAIL arb_idle: grant=%0d bus=%h, required grant=0 bus=%h", cur_grant(), bus_now(), BUS_NOP);
    end
  endtask

  task automatic test_rw_alternate();
    int got, lat, exp;
    bit bus_ok, held_ok, nop_ok;
    exp_q.push_back(G_WR); exp_q.push_back(G_RD);
    exp_q.push_back(G_WR); exp_q.push_back(G_RD);
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      grant_cycle(4, (k == 3) ? 2 : 0, got, lat, bus_ok, held_ok, nop_ok);
      exp = pop_exp();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rw_order[%0d]: got grant %0d, required %0d", k, got, exp);
      end
      vectors++;
      if (lat !== 1) begin
        miscompares++;
        $display("FAIL rw_latency[%0d]: got %0d cycles, required 1", k, lat);
      end
      vectors++;
      if (!bus_ok) begin
        miscompares++;
        $display("FAIL rw_bus[%0d]: bus did not carry module %0d", k, got);
      end
      vectors++;
      if (!held_ok) begin
        miscompares++;
        $display("FAIL rw_hold[%0d]: grant %0d not held through foreign done", k, got);
      end
      vectors++;
      if (!nop_ok) begin
        miscompares++;
        $display("FAIL rw_nop_gap[%0d]: grant=%0d bus=%h, required grant=0 bus=%h", k, cur_grant(), bus_now(), BUS_NOP);
      end
    end
  endtask

  task automatic test_priority();
    int got, lat, exp, n;
    bit bus_ok, held_ok, nop_ok;
    exp_q.push_back(G_AREF);
`ifdef SDRAM_ARB_SREF_EN
    exp_q.push_back(G_SREF);
`endif
    exp_q.push_back(G_WR);
    n = exp_q.size();
    aref_req = 1'b1;
    sref_req = 1'b1;
    wr_req   = 1'b1;
    for (int k = 0; k < n; k++) begin
      grant_cycle(3, 1, got, lat, bus_ok, held_ok, nop_ok);
      exp = pop_exp();
      vectors++;
      if (got !== exp || !bus_ok || !held_ok || !nop_ok || lat !== 1) begin
        miscompares++;
        $display("FAIL prio[%0d]: grant=%0d lat=%0d bus_ok=%b held_ok=%b nop_ok=%b, required grant=%0d lat=1 all ok",
                 k, got, lat, bus_ok, held_ok, nop_ok, exp);
      end
    end
    sref_req = 1'b0;
    repeat (2) tick();
    vectors++;
    if (cur_grant() !== G_NONE || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL prio_drain: grant=%0d pending=%0d, required 0 and 0", cur_grant(), exp_q.size());
    end
  endtask

`ifdef SDRAM_ARB_SREF_EN
  task automatic test_sref();
    int got, lat;
    sref_cke = 1'b0;
    sref_req = 1'b1;
    wait_grant(got, lat);
    vectors++;
    if (got !== G_SREF) begin
      miscompares++;
      $display("FAIL sref_grant: got %0d, required %0d", got, G_SREF);
    end
    aref_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (sdram_cke !== 1'b0 || aref_en !== 1'b0 || sref_en !== 1'b1) begin
        miscompares++;
        $display("FAIL sref_hold c%0d: cke=%b aref_en=%b sref_en=%b, required 0 0 1", c, sdram_cke, aref_en, sref_en);
      end
    end
    sref_done = 1'b1;
    sref_req  = 1'b0;
    tick();
    sref_done = 1'b0;
    sref_cke  = 1'b1;
    vectors++;
    if (cur_grant() !== G_NONE || sdram_cke !== 1'b1) begin
      miscompares++;
      $display("FAIL sref_exit: grant=%0d cke=%b, required 0 and 1", cur_grant(), sdram_cke);
    end
    tick();
    vectors++;
    if (cur_grant() !== G_AREF) begin
      miscompares++;
      $display("FAIL sref_aref_next: grant=%0d, required %0d", cur_grant(), G_AREF);
    end
    aref_done = 1'b1;
    aref_req  = 1'b0;
    tick();
    aref_done = 1'b0;
  endtask
`else
  task automatic test_sref();
    int got, lat;
    sref_cke = 1'b0;
    sref_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      vectors++;
      if (sref_en !== 1'b0 || sdram_cke !== 1'b1 || cur_grant() !== G_NONE) begin
        miscompares++;
        $display("FAIL sref_ignored c%0d: sref_en=%b cke=%b grant=%0d, required 0 1 0", c, sref_en, sdram_cke, cur_grant());
      end
    end
    rd_req = 1'b1;
    wait_grant(got, lat);
    vectors++;
    if (got !== G_RD || sdram_cke !== 1'b1 || bus_now() !== bus_exp(G_RD)) begin
      miscompares++;
      $display("FAIL sref_off_rd: grant=%0d cke=%b bus=%h, required %0d 1 %h", got, sdram_cke, bus_now(), G_RD, bus_exp(G_RD));
    end
    rd_done = 1'b1;
    rd_req  = 1'b0;
    tick();
    rd_done  = 1'b0;
    sref_req = 1'b0;
    sref_cke = 1'b1;
  endtask
`endif

  task automatic test_reset_mid_write();
    int got, lat, exp;
    bit bus_ok, held_ok, nop_ok;
    wr_req = 1'b1;
    wait_grant(got, lat);
    vectors++;
    if (got !== G_WR) begin
      miscompares++;
      $display("FAIL rst_pre_write: grant=%0d, required %0d", got, G_WR);
    end
    tick();
    #3;
    sys_rst_n = 1'b0;
    init_done = 1'b0;
    wr_req    = 1'b0;
    #1;
    vectors++;
    if (wr_en !== 1'b0 || cur_grant() !== G_NONE || sdram_cke !== 1'b1 ||
        bus_now() !== {init_cmd, init_ba, init_addr}) begin
      miscompares++;
      $display("FAIL rst_mid_write: wr_en=%b grant=%0d cke=%b bus=%h, required 0 0 1 %h",
               wr_en, cur_grant(), sdram_cke, bus_now(), {init_cmd, init_ba, init_addr});
    end
    tick();
    sys_rst_n = 1'b1;
    repeat (2) tick();
    vectors++;
    if (cur_grant() !== G_NONE || bus_now() !== {init_cmd, init_ba, init_addr}) begin
      miscompares++;
      $display("FAIL rst_requalify: grant=%0d bus=%h, required 0 %h", cur_grant(), bus_now(), {init_cmd, init_ba, init_addr});
    end
    // last_rw was 1 before reset; after reset the tie must go to write again
    exp_q.push_back(G_WR);
    init_done = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    tick();
    grant_cycle(2, 2, got, lat, bus_ok, held_ok, nop_ok);
    exp = pop_exp();
    vectors++;
    if (got !== exp || !bus_ok || !nop_ok) begin
      miscompares++;
      $display("FAIL rst_tie: grant=%0d bus_ok=%b nop_ok=%b, required grant=%0d 1 1", got, bus_ok, nop_ok, exp);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    init_done = 1'b0;
    init_cmd = 4'b0001; init_ba = 2'b01; init_addr = 12'h111;
    aref_cmd = 4'b0001; aref_ba = 2'b10; aref_addr = 12'h222; aref_req = 1'b0; aref_done = 1'b0;
    sref_cmd = 4'b0100; sref_ba = 2'b11; sref_addr = 12'h333; sref_req = 1'b0; sref_done = 1'b0;
    sref_cke = 1'b1;
    wr_cmd = 4'b0100; wr_ba = 2'b01; wr_addr = 12'h444; wr_req = 1'b0; wr_done = 1'b0;
    rd_cmd = 4'b0101; rd_ba = 2'b10; rd_addr = 12'h555; rd_req = 1'b0; rd_done = 1'b0;
    test_reset();
    test_rw_alternate();
    test_priority();
    test_sref();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_arbiter.md
# sdram_cmd_arbiter

Central sequencer and command-bus arbiter for the SDRAM controller. It holds the bus for the init module until `init_done`, then grants the shared SDRAM command/address bus to one of four sub-modules: auto-refresh, self-refresh, write and read. It multiplexes the granted module's `sdram_cmd`/`sdram_ba`/`sdram_addr`/`sdram_cke` onto the device pins and issues NOP whenever no grant is active. It sits between the sub-modules and the SDRAM device model.

## Interface
Parameters:
- `CMD_NOP`, 4'b0111: NOP encoding of {cs_n, ras_n, cas_n, we_n}.

Ports:
- `sys_clk`  in  1  system clock; all state updates on its rising edge.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `init_done`  in  1  level from the init module; high once power-up init is complete.
- `init_cmd`/`init_ba`/`init_addr`  in  4/2/12  init module bus.
- `aref_req`  in  1  level request from the auto-refresh module.
- `aref_done`  in  1  one-cycle completion pulse.
- `aref_cmd`/`aref_ba`/`aref_addr`  in  4/2/12  auto-refresh module bus.
- `sref_req`  in  1  level request for self-refresh.
- `sref_done`  in  1  one-cycle pulse after self-refresh exit.
- `sref_cmd`/`sref_ba`/`sref_addr`/`sref_cke`  in  4/2/12/1  self-refresh module bus.
- `wr_req`  in  1  level request from the write module.
- `wr_done`  in  1  one-cycle completion pulse.
- `wr_cmd`/`wr_ba`/`wr_addr`  in  4/2/12  write module bus.
- `rd_req`  in  1  level request from the read module.
- `rd_done`  in  1  one-cycle completion pulse.
- `rd_cmd`/`rd_ba`/`rd_addr`  in  4/2/12  read module bus.
- `aref_en`, `sref_en`, `wr_en`, `rd_en`  out  1 each  grant levels; at most one high at any time.
- `sdram_cke`  out  1  clock enable to the device.
- `sdram_cmd`/`sdram_ba`/`sdram_addr`  out  4/2/12  device command bus.

## Operation
- States: INIT, ARB, AREF, SREF, WRITE, READ. The state register resets to INIT.
- INIT -> ARB on the first edge with `init_done`=1. No grants are issued in INIT.
- ARB selects by fixed priority: `aref_req` > `sref_req` > write/read.
- Write/read tie (both requests high): the grant alternates. A `last_rw` flag (reset 0 = read) is set to 1 when WRITE is entered and cleared to 0 when READ is entered. When both are pending, the block grants the one that was not served last. With `last_rw`=0 after reset, the first tie goes to WRITE.
- A granted state holds until its own done pulse, then returns to ARB. There is no pre-emption. Requests that arrive mid-grant stay pending as levels.
- Done pulses belonging to non-granted modules are ignored.
- In ARB with no request, the block stays in ARB.
- Grant outputs are decoded combinationally from the state register (e.g. `wr_en` = state==WRITE).
- Bus multiplexing is combinational from the state:
  - INIT: init bus.
  - AREF/SREF/WRITE/READ: the corresponding module's bus.
  - ARB: `CMD_NOP`, ba 2'b00, addr 12'h000.
- `sdram_cke` = `sref_cke` in SREF, otherwise 1.
- `aref_req` raised during SREF is not serviced until SREF exits; it then wins the next ARB.

## Timing
- Reset (async assert): state INIT; all `*_en` = 0; `sdram_cke` = 1; bus follows the init inputs; `last_rw` = 0.
- Deassertion of reset is synchronous in effect: the first transition happens on the first edge with `sys_rst_n`=1.
- Request in ARB at edge N: the state changes at N, and the grant is high from N until the edge that samples the done pulse.
- Done sampled at edge M: ARB from M to M+1 (one NOP cycle minimum between grants). The next grant is at M+1.
- Minimum request-to-grant latency is 1 cycle; there is no combinational path from req to grant.
- Reset asserted mid-grant: the grant drops immediately and the state returns to INIT; `init_done` must re-qualify.

## Configuration
- `SDRAM_ARB_SREF_EN` defined: SREF state and `sref_*` handling present as above.
- Not defined:
  - `sref_req`, `sref_done` and the `sref_*` bus are ignored.
  - `sref_en` is tied 0 and `sdram_cke` is tied 1.
  - Ports remain present for pin compatibility.

## Test plan
- Reset, then `init_done`=1 at cycle 5 -> state ARB at cycle 6; `sdram_cmd`=4'b0111, all grants 0.
- `wr_req`=1 and `rd_req`=1 held, each done pulsed 4 cycles after its grant -> grant order WRITE, READ, WRITE, READ, with 1 NOP cycle between grants.
- `aref_req`, `sref_req` and `wr_req` all rise on the same edge -> AREF first, then SREF, then WRITE.
- In SREF with `sref_cke`=0, `aref_req`=1 -> `sdram_cke`=0 and `aref_en`=0 until `sref_done`; `aref_en`=1 one cycle after ARB.
- Reset asserted mid-WRITE -> `wr_en`=0 immediately, state INIT, bus mirrors the init inputs.
- Build without `SDRAM_ARB_SREF_EN`, `sref_req`=1 -> `sref_en` stays 0, `sdram_cke` stays 1, write/read still granted.
